// File: rtl/posit_op_pkg.sv
// posit_op_pkg: shared op codes, register map, status bit indices and FSM states for posit_op_ctrl
//   OP_*      : CMD op field encoding (0 = none, 1 = add, 2 = mul, 3 = div)
//   ADDR_*    : register offsets decoded from addr[4:0]
//   ST_*      : STATUS register bit positions
//   be_merge  : byte-enable merge of a bus write into a 32-bit register image
package posit_op_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_MUL  = 2'd2,
        OP_DIV  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } ctrl_state_e;

    localparam logic [4:0] ADDR_A    = 5'h00;
    localparam logic [4:0] ADDR_B    = 5'h04;
    localparam logic [4:0] ADDR_CMD  = 5'h08;
    localparam logic [4:0] ADDR_RES  = 5'h0C;
    localparam logic [4:0] ADDR_STAT = 5'h10;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_INF  = 2;
    localparam int ST_ZERO = 3;
    localparam int ST_TOUT = 4;
    localparam int ST_ERR  = 5;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/posit_op_ctrl.sv
// posit_op_ctrl: memory-mapped sequencer issuing one posit add/mul/div operation at a time
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   req_i/we_i/be_i/addr_i/wdata_i : bus request (addr_i[4:0] decoded)
//   rvalid_o/rdata_o               : registered response, one cycle after req_i
//   op_a_o/op_b_o                  : operands straight from the A/B registers
//   unit_start_o                   : one-hot start {div, mul, add}, held until done/timeout
//   unit_done_i, *_res_i           : per-unit completion and results
//   unit_inf_i/unit_zero_i         : per-unit result flags
module posit_op_ctrl
    import posit_op_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic [N-1:0]  op_a_o,
    output logic [N-1:0]  op_b_o,
    output logic [2:0]    unit_start_o,
    input  logic [2:0]    unit_done_i,
    input  logic [N-1:0]  add_res_i,
    input  logic [N-1:0]  mul_res_i,
    input  logic [N-1:0]  div_res_i,
    input  logic [2:0]    unit_inf_i,
    input  logic [2:0]    unit_zero_i
);

    ctrl_state_e    state_q, state_d;
    op_e            op_q, op_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic           done_q, done_d, inf_q, inf_d, zero_q, zero_d, to_q, to_d, err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rvalid_q;
    logic [31:0]    rdata_q, rdata_d;

    logic [4:0]     addr;
    logic           wr, rd, busy, sel_done, sel_inf, sel_zero, prot_wr;
    logic [2:0]     op_oh;
    logic [N-1:0]   sel_res;
    logic [5:0]     status;
    logic           unused_addr;

    assign addr        = addr_i[4:0];
    assign unused_addr = ^addr_i[31:5];
    assign wr          = req_i & we_i;
    assign rd          = req_i & ~we_i;
    assign busy        = state_q != S_IDLE;
    // Only the selected unit's signals matter; the other units' done/flags are ignored.
    assign op_oh    = {op_q == OP_DIV, op_q == OP_MUL, op_q == OP_ADD};
    assign sel_done = |(unit_done_i & op_oh);
    assign sel_inf  = |(unit_inf_i & op_oh);
    assign sel_zero = |(unit_zero_i & op_oh);
    assign sel_res  = op_q == OP_ADD ? add_res_i : op_q == OP_MUL ? mul_res_i : div_res_i;
    assign prot_wr  = wr && (addr == ADDR_A || addr == ADDR_B || addr == ADDR_CMD);
    assign status   = {err_q, to_q, zero_q, inf_q, done_q, busy};

    assign unit_start_o = busy ? op_oh : 3'b000;
    assign op_a_o       = a_q;
    assign op_b_o       = b_q;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        done_d  = done_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        to_d    = to_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        if (rd)
            rdata_d = addr == ADDR_A    ? 32'(a_q)   :
                      addr == ADDR_B    ? 32'(b_q)   :
                      addr == ADDR_RES  ? 32'(res_q) :
                      addr == ADDR_STAT ? 32'(status) : 32'h0;
        if (rd && addr == ADDR_RES) begin
            done_d = 1'b0;
            inf_d  = 1'b0;
            zero_d = 1'b0;
            to_d   = 1'b0;
        end
        if (prot_wr && busy)
            err_d = 1'b1;
        else if (wr && addr == ADDR_A)
            a_d = N'(be_merge(32'(a_q), wdata_i, be_i));
        else if (wr && addr == ADDR_B)
            b_d = N'(be_merge(32'(b_q), wdata_i, be_i));
        else if (wr && addr == ADDR_CMD && be_i[0]) begin
            if (op_e'(wdata_i[1:0]) == OP_NONE)
                err_d = 1'b1;
            else begin
                err_d   = 1'b0;
                op_d    = op_e'(wdata_i[1:0]);
                done_d  = 1'b0;
                inf_d   = 1'b0;
                zero_d  = 1'b0;
                to_d    = 1'b0;
                state_d = S_ISSUE;
            end
        end
        // Completion/timeout is evaluated after the RESULT-read clear so a same-cycle
        // read cannot wipe the freshly set flags.
        if (state_q == S_ISSUE) begin
            cnt_d   = '0;
            state_d = S_WAIT;
        end else if (state_q == S_WAIT) begin
            if (sel_done) begin
                res_d   = sel_res;
                inf_d   = sel_inf;
                zero_d  = sel_zero;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                res_d   = '0;
                to_d    = 1'b1;
                state_d = S_IDLE;
            end else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            to_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            done_q   <= done_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            to_q     <= to_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_posit_op_ctrl.sv
// tb_posit_op_ctrl: vectors, directed corner sequences and randomized traffic against a transaction-level model
module tb_posit_op_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rvalid;
    logic [31:0] rdata, op_a, op_b;
    logic [2:0]  start, done_in;
    logic [31:0] add_res = '0, mul_res = '0, div_res = '0;
    logic [2:0]  inf_in = '0, zero_in = '0;

    int checks = 0, errors = 0;
    int dly[3] = '{1000, 1000, 1000};
    int k[3] = '{0, 0, 0};
    bit noise_en = 1'b0;
    logic [2:0] noise_r;
    int st_any = 0, st_add = 0;
    int cyc = 0;

    posit_op_ctrl #(.N(32), .TIMEOUT(TO), .CW(7)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .op_a_o(op_a), .op_b_o(op_b),
        .unit_start_o(start), .unit_done_i(done_in), .add_res_i(add_res), .mul_res_i(mul_res),
        .div_res_i(div_res), .unit_inf_i(inf_in), .unit_zero_i(zero_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unit stubs: a unit raises done once its start has been seen dly+2 negedges (ISSUE + dly WAIT cycles).
    always @(negedge clk) begin
        noise_r = noise_en ? 3'($urandom) : 3'b000;
        for (int u = 0; u < 3; u++) begin
            k[u] = start[u] ? k[u] + 1 : 0;
            done_in[u] = (start[u] && k[u] >= dly[u] + 2) || (noise_r[u] && !start[u]);
        end
        if (start != 3'b000) st_any++;
        if (start == 3'b001) st_add++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] r, output logic v);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        r = rdata; v = rvalid;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
        logic [31:0] r;
        logic v;
        bus(1'b1, a, b, d, r, v);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic v;
        bus(1'b0, a, 4'hF, 32'h0, r, v);
        chk(nm, r, exp);
        chk({nm, " rvalid"}, 32'(v), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[15];

    // Transaction-level reference model for the random phase.
    logic [31:0] ma, mb, mres, p_res;
    bit md, mi, mz, mt, me, pend, p_done, p_inf, p_zero, p_to;
    int p_end;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    task automatic m_settle(input int c);
        if (pend && c >= p_end) begin
            pend = 1'b0;
            mres = p_res; md = p_done; mi = p_inf; mz = p_zero; mt = p_to;
        end
    endtask

    task automatic rnd_read(input logic [4:0] a5);
        logic [31:0] e;
        m_settle(cyc);
        e = a5 == 5'h00 ? ma : a5 == 5'h04 ? mb : a5 == 5'h0C ? mres :
            a5 == 5'h10 ? {26'd0, me, mt, mz, mi, md, pend} : 32'h0;
        if (a5 == 5'h0C) begin md = 0; mi = 0; mz = 0; mt = 0; end
        rd_chk($sformatf("rnd rd %h", a5), {27'($urandom), a5}, e);
    endtask

    initial begin
        logic [31:0] r;
        logic v;
        int kind, op, d, u;
        logic [3:0] b;
        logic [31:0] wd;
        logic [4:0] picks[8];

        idle(3);
        rst = 1'b0;
        chk("reset start", 32'(start), 32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset A out", op_a, 32'h0);
        rd_chk("reset status", 32'h10, 32'h0);
        rd_chk("reset result", 32'h0C, 32'h0);

        tv[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1122_3344, 32'h0};
        tv[1]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h1122_3344};
        tv[2]  = '{1'b1, 32'h0000_0004, 4'hC, 32'hFFFF_FFFF, 32'h0};
        tv[3]  = '{1'b0, 32'h0000_0004, 4'hF, 32'h0,         32'hFFFF_0000};
        tv[4]  = '{1'b0, 32'hFFFF_FFE4, 4'hF, 32'h0,         32'hFFFF_0000};
        tv[5]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0};
        tv[6]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h0};
        tv[7]  = '{1'b1, 32'h0000_0018, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tv[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h1122_3344};
        tv[9]  = '{1'b1, 32'h0000_0008, 4'hE, 32'h0000_0001, 32'h0};
        tv[10] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h0};
        tv[11] = '{1'b1, 32'h0000_0008, 4'h1, 32'h0000_0000, 32'h0};
        tv[12] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h20};
        tv[13] = '{1'b1, 32'h0000_0003, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tv[14] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h1122_3344};
        for (int i = 0; i < 15; i++) begin
            bus(tv[i].w, tv[i].a, tv[i].b, tv[i].d, r, v);
            chk($sformatf("vec%0d rvalid", i), 32'(v), 32'd1);
            if (!tv[i].w) chk($sformatf("vec%0d rdata", i), r, tv[i].exp);
        end

        // 1: add with done at first WAIT cycle
        do_reset();
        add_res = 32'h4800_0000; dly[0] = 0;
        wr(32'h00, 32'h4000_0000);
        wr(32'h04, 32'h4000_0000);
        st_any = 0; st_add = 0;
        wr(32'h08, 32'h1);
        idle(1);
        rd_chk("t1 busy T+2", 32'h10, 32'h01);
        rd_chk("t1 status T+3", 32'h10, 32'h02);
        rd_chk("t1 result", 32'h0C, 32'h4800_0000);
        chk("t1 start add cycles", st_add, 2);
        chk("t1 start any cycles", st_any, 2);

        // 2: div delayed 10 cycles, RESULT read clears done
        div_res = 32'h3C00_0000; dly[2] = 10;
        wr(32'h08, 32'h3);
        for (int i = 1; i <= 12; i++) rd_chk($sformatf("t2 busy T+%0d", i), 32'h10, 32'h01);
        rd_chk("t2 done T+13", 32'h10, 32'h02);
        rd_chk("t2 result", 32'h0C, 32'h3C00_0000);
        rd_chk("t2 cleared", 32'h10, 32'h00);

        // 3: mul never completes, other units' done bits toggling
        noise_en = 1'b1; dly[1] = 1000;
        wr(32'h08, 32'h2);
        idle(TO);
        rd_chk("t3 busy T+65", 32'h10, 32'h01);
        rd_chk("t3 timeout T+66", 32'h10, 32'h10);
        rd_chk("t3 result zero", 32'h0C, 32'h0);
        noise_en = 1'b0;

        // 4: writes while busy are dropped and flag err
        add_res = 32'h4100_0000; dly[0] = 5; st_add = 0;
        wr(32'h08, 32'h1);
        wr(32'h00, 32'h1234_5678);
        wr(32'h08, 32'h1);
        chk("t4 op_a held", op_a, 32'h4000_0000);
        idle(7);
        rd_chk("t4 status", 32'h10, 32'h22);
        rd_chk("t4 A unchanged", 32'h00, 32'h4000_0000);
        chk("t4 no restart", st_add, 7);
        wr(32'h08, 32'h1);
        rd_chk("t4 err cleared", 32'h10, 32'h01);
        idle(10);
        rd_chk("t4 done", 32'h10, 32'h02);
        rd_chk("t4 result", 32'h0C, 32'h4100_0000);

        // 5: partial byte write, op=0 command
        wr(32'h00, 32'h0);
        wr(32'h00, 32'hAAAA_5555, 4'b0011);
        rd_chk("t5 A bytes", 32'h00, 32'h0000_5555);
        wr(32'h08, 32'h0);
        rd_chk("t5 op0 err", 32'h10, 32'h20);

        // 6: reset during WAIT
        wr(32'h00, 32'h1);
        wr(32'h04, 32'h2);
        dly[2] = 1000;
        wr(32'h08, 32'h3);
        idle(3);
        chk("t6 start before rst", 32'(start), 32'h4);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10;
        @(negedge clk);
        chk("t6 start dropped", 32'(start), 32'h0);
        chk("t6 rvalid low", 32'(rvalid), 32'h0);
        chk("t6 op_b cleared", op_b, 32'h0);
        rst = 1'b0; req = 1'b0;
        rd_chk("t6 status", 32'h10, 32'h0);
        rd_chk("t6 A", 32'h00, 32'h0);
        rd_chk("t6 B", 32'h04, 32'h0);

        // Random traffic against the transaction model
        do_reset();
        ma = 0; mb = 0; mres = 0; md = 0; mi = 0; mz = 0; mt = 0; me = 0; pend = 0;
        picks = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h02};
        noise_en = 1'b1;
        for (int it = 0; it < 400; it++) begin
            m_settle(cyc);
            kind = $urandom_range(0, 11);
            wd = $urandom;
            b = 4'($urandom);
            if (kind <= 3) begin
                if (pend) me = 1'b1;
                else if (kind <= 1) ma = mrg(ma, wd, b);
                else mb = mrg(mb, wd, b);
                wr({27'($urandom), kind <= 1 ? 5'h00 : 5'h04}, wd, b);
                if (kind <= 1) chk("rnd op_a", op_a, ma);
                else chk("rnd op_b", op_b, mb);
            end else if (kind <= 6) begin
                op = $urandom_range(0, 3);
                if ($urandom_range(0, 3) != 0) b = 4'hF;
                if (pend) me = 1'b1;
                else if (b[0] && op == 0) me = 1'b1;
                else if (b[0]) begin
                    u = op - 1;
                    d = $urandom_range(0, 7) == 0 ? 1000 : $urandom_range(0, 12);
                    dly[u] = d;
                    add_res = $urandom; mul_res = $urandom; div_res = $urandom;
                    inf_in = 3'($urandom); zero_in = 3'($urandom);
                    me = 0; md = 0; mi = 0; mz = 0; mt = 0; pend = 1;
                    if (d < TO) begin
                        p_end = cyc + 3 + d;
                        p_res = u == 0 ? add_res : u == 1 ? mul_res : div_res;
                        p_done = 1; p_inf = inf_in[u]; p_zero = zero_in[u]; p_to = 0;
                    end else begin
                        p_end = cyc + 2 + TO;
                        p_res = 0; p_done = 0; p_inf = 0; p_zero = 0; p_to = 1;
                    end
                end
                wr({27'($urandom), 5'h08}, {wd[31:2], 2'(op)}, b);
            end else if (kind <= 10)
                rnd_read(picks[$urandom_range(0, 7)]);
            else
                idle($urandom_range(1, 20));
        end
        idle(2 * TO);
        rnd_read(5'h10);
        rnd_read(5'h0C);
        rnd_read(5'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_op_ctrl.md
Name: posit_op_ctrl

Overview:
Memory-mapped sequencer for the posit arithmetic units: posit_add, posit_mult and posit_div.
- Holds operand, command, result and status registers behind a simple req/we/be/addr/wdata bus.
- Issues one operation at a time to the selected unit using a start/done handshake.
- Captures the result and its inf/zero flags, and enforces a timeout.
- Sits between the core data bus and the posit unit datapath.

Parameters:
N, 32, posit word width; must be no greater than 32.
TIMEOUT, 64, maximum WAIT cycles before an operation is aborted.
CW, 7, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_i  in  1  bus request
we_i  in  1  write enable
be_i  in  4  byte enables
addr_i  in  32  byte address; only addr_i[4:0] is decoded
wdata_i  in  32  write data
rvalid_o  out  1  response valid, one cycle after req_i
rdata_o  out  32  read data
op_a_o  out  N  operand A to all units
op_b_o  out  N  operand B to all units
unit_start_o  out  3  one-hot start: bit0 ADD, bit1 MUL, bit2 DIV
unit_done_i  in  3  per-unit done
add_res_i / mul_res_i / div_res_i  in  N each  unit results
unit_inf_i  in  3  per-unit inf flag
unit_zero_i  in  3  per-unit zero flag

Behaviour:
- Register map (addr_i[4:0]):
  - 0x00 A: read/write.
  - 0x04 B: read/write.
  - 0x08 CMD: write only; op = wdata_i[1:0], where 1 = ADD, 2 = MUL, 3 = DIV.
  - 0x0C RESULT: read only.
  - 0x10 STATUS: read only. bit0 busy, bit1 done, bit2 inf, bit3 zero, bit4 timeout, bit5 err.
  - Unmapped addresses read 0; writes to them are ignored.
- A/B writes update only the bytes selected by be_i. CMD is accepted only when be_i[0] = 1.
- Accepted while busy (any FSM state other than IDLE): writes to A, B or CMD are dropped and set err.
- A CMD write with op = 0 sets err and does not start an operation.
- err clears only on a CMD write that is accepted.
- rvalid_o is req_i registered by one cycle, for reads and writes alike.
- rdata_o is registered and reflects register contents at the request cycle, i.e. before any same-cycle update.
- A read of RESULT clears done, inf, zero and timeout on the next edge.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE on an accepted CMD write (cycle T). Latch op; clear done, inf, zero and timeout.
  - ISSUE (T+1): assert unit_start_o one-hot for op; reset the counter to 0; go to WAIT.
  - WAIT: hold unit_start_o. Sample only unit_done_i[op]; done bits of other units are ignored.
    - If done: latch the selected result into RESULT, latch inf/zero from that unit, set done, go to IDLE. unit_start_o drops on the same edge.
    - Otherwise increment the counter. When counter == TIMEOUT-1 and done is still low: RESULT <= 0, set timeout, go to IDLE.
- Minimum latency: CMD write at T, done seen in the T+2 cycle, RESULT/done visible and busy low from T+3.
- busy = (state != IDLE).
- op_a_o / op_b_o are driven directly from the A/B registers, so they are stable for the whole operation because writes are blocked while busy.
- Reset: all registers, outputs and counter go to 0; state goes to IDLE.
  - A reset mid-operation drops unit_start_o at the next edge and discards the in-flight result.
- A RESULT read in the same cycle that done is set: returns the old RESULT; the clear is suppressed so the new done survives.

Decomposition:
- Package posit_op_pkg:
  - op codes OP_NONE, OP_ADD, OP_MUL, OP_DIV.
  - address constants ADDR_A, ADDR_B, ADDR_CMD, ADDR_RES, ADDR_STAT.
  - STATUS bit indices.
  - state enum ctrl_state_e.
- No sub-module is needed. The result/flag mux is inline; the timeout counter is inline.

Test Plan:
1. Write A = 0x40000000 (1.0) and B = 0x40000000, then CMD = 1. Stub add unit asserts done at the first WAIT cycle with 0x48000000. Expect RESULT = 0x48000000, STATUS = 0x02 at T+3, and unit_start_o = 3'b001 for exactly 2 cycles.
2. CMD = 3 with the div stub delaying done by 10 cycles; poll STATUS. Expect busy = 1 throughout. Then done = 1 at T+13; reading RESULT clears done (STATUS = 0x00 on the next read).
3. CMD = 2 with mul done never asserted. Expect STATUS = 0x10 and RESULT = 0 after TIMEOUT WAIT cycles; busy falls at T+2+TIMEOUT.
4. While busy, write A = 0x12345678 and CMD = 1. Expect A unchanged, no restart, and err = 1. The next accepted CMD clears err.
5. Write A with be_i = 4'b0011 and wdata_i = 0xAAAA5555 over A = 0. Expect A = 0x00005555. Then write CMD = 0: expect err = 1 and busy = 0.
6. Assert rst_i during WAIT. Expect unit_start_o = 0, STATUS = 0, A = B = 0 one cycle later, and rvalid_o = 0.
